mc_controller: RTL and testbench

Multicycle control unit that sequences the shared-ALU, shared-memory MIPS-subset datapath through fetch, decode and per-instruction execute states. A Moore FSM drives every mux select and write enable of the datapath. The only Mealy term is the PC enable, which depends on the ALU `zero` flag in the branch state. The controller sits beside the datapath in the processor top and replaces the single-cycle combinational decoder.

---
 rtl/mc_controller.sv | 212 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS-subset control FSM (Moore, Mealy pcen).
// Optional: define MC_CONTROLLER_BNE_EN to add bne (op 000101).
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   op, funct, zero     - opcode/funct from IR, ALU zero flag
//   pcen, irwrite,      - datapath write enables
//   memwrite, regwrite
//   iord, alusrca,      - datapath mux selects
//   alusrcb, regdst,
//   memtoreg, pcsrc
//   alucontrol          - ALU operation
//   done, illegal       - retire / unsupported-instruction pulses
//   instr_count         - retired instruction count (wraps)
//   state               - current FSM state, for debug
module mc_controller #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  input  logic         zero,
  output logic         pcen,
  output logic         irwrite,
  output logic         memwrite,
  output logic         regwrite,
  output logic         iord,
  output logic         alusrca,
  output logic [1:0]   alusrcb,
  output logic         regdst,
  output logic         memtoreg,
  output logic [1:0]   pcsrc,
  output logic [2:0]   alucontrol,
  output logic         done,
  output logic         illegal,
  output logic [N-1:0] instr_count,
  output logic [3:0]   state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t cur, nxt, dec;
  logic   pcwrite, branch, brcond;
  logic   irw, mw, rw, dn, ill;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= FETCH;
      instr_count <= '0;
    end else begin
      cur <= nxt;
      if (done)
        instr_count <= instr_count + ONE;
    end
  end

`ifdef MC_CONTROLLER_BNE_EN
  // Branch polarity latched while op is decoded.
  logic isbne;

  always_ff @(posedge clk) begin
    if (reset)
      isbne <= 1'b0;
    else if (cur == DECODE)
      isbne <= (op == OP_BNE);
  end

  assign brcond = isbne ? ~zero : zero;
`else
  assign brcond = zero;
`endif

  // Reset shows FETCH selects; enables are masked below.
  assign dec = reset ? FETCH : cur;

  always_comb begin
    nxt        = FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    irw        = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    dn         = 1'b0;
    ill        = 1'b0;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    unique case (dec)
      FETCH: begin
        nxt     = DECODE;
        alusrcb = 2'b01;
        irw     = 1'b1;
        pcwrite = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXEC;
          OP_BEQ:       nxt = BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:       nxt = BRANCH;
`endif
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JUMP;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
            dn  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        nxt     = (op == OP_LW) ? MEMRD : MEMWR;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        nxt  = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        rw       = 1'b1;
        dn       = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        mw   = 1'b1;
        dn   = 1'b1;
      end
      EXEC: begin
        nxt     = ALUWB;
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   ill        = 1'b1;
        endcase
      end
      ALUWB: begin
        regdst = 1'b1;
        rw     = 1'b1;
        dn     = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        dn         = 1'b1;
      end
      ADDIEX: begin
        nxt     = ADDIWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        rw = 1'b1;
        dn = 1'b1;
      end
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        dn      = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  assign pcen     = ~reset & (pcwrite | (branch & brcond));
  assign irwrite  = ~reset & irw;
  assign memwrite = ~reset & mw;
  assign regwrite = ~reset & rw;
  assign done     = ~reset & dn;
  assign illegal  = ~reset & ill;
  assign state    = cur;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: table-driven check of mc_controller outputs
// cycle by cycle, plus branch-zero and mid-instruction reset cases.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        pcen, irwrite, memwrite, regwrite;
  logic        iord, alusrca, regdst, memtoreg;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic        done, illegal;
  logic [31:0] instr_count;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  mc_controller #(.N(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .iord(iord), .alusrca(alusrca),
    .alusrcb(alusrcb), .regdst(regdst), .memtoreg(memtoreg),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .done(done),
    .illegal(illegal), .instr_count(instr_count), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {state, en(pcen irw mw rw), sel(iord asa asb rd m2r pcs), alu, done ill}
  typedef struct {
    logic        r;
    logic [5:0]  o;
    logic [5:0]  f;
    logic        z;
    logic [20:0] exp;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [5:0] o,
                     input logic [5:0] f, input logic z,
                     input logic [3:0] st, input logic [3:0] en,
                     input logic [7:0] sel, input logic [2:0] alu,
                     input logic [1:0] di, input int cnt);
    vec_t v;
    v.r = r; v.o = o; v.f = f; v.z = z;
    v.exp = {st, en, sel, alu, di};
    v.cnt = cnt;
    tbl.push_back(v);
  endtask

  function automatic logic [20:0] actual();
    return {state, pcen, irwrite, memwrite, regwrite,
            iord, alusrca, alusrcb, regdst, memtoreg, pcsrc,
            alucontrol, done, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011,
    RT = 6'b000000, BEQ = 6'b000100, ADDI = 6'b001000,
    J = 6'b000010, BAD = 6'b111111, BNE = 6'b000101;

  initial begin
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;

    // reset cycles
    add(1, RT, 0, 0, 0, 4'b0000, 8'b00010000, 3'b010, 2'b00, 0);
    add(1, RT, 0, 0, 0, 4'b0000, 8'b00010000, 3'b010, 2'b00, 0);
    // lw
    add(0, LW, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 0);
    add(0, LW, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 0);
    add(0, LW, 0, 0, 2, 4'b0000, 8'b01100000, 3'b010, 2'b00, 0);
    add(0, LW, 0, 0, 3, 4'b0000, 8'b10000000, 3'b010, 2'b00, 0);
    add(0, LW, 0, 0, 4, 4'b0001, 8'b00000100, 3'b010, 2'b10, 0);
    // sub
    add(0, RT, 6'b100010, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 1);
    add(0, RT, 6'b100010, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 1);
    add(0, RT, 6'b100010, 0, 6, 4'b0000, 8'b01000000, 3'b110, 2'b00, 1);
    add(0, RT, 6'b100010, 0, 7, 4'b0001, 8'b00001000, 3'b010, 2'b10, 1);
    // slt
    add(0, RT, 6'b101010, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 2);
    add(0, RT, 6'b101010, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 2);
    add(0, RT, 6'b101010, 0, 6, 4'b0000, 8'b01000000, 3'b111, 2'b00, 2);
    add(0, RT, 6'b101010, 0, 7, 4'b0001, 8'b00001000, 3'b010, 2'b10, 2);
    // beq taken
    add(0, BEQ, 0, 1, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 3);
    add(0, BEQ, 0, 1, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 3);
    add(0, BEQ, 0, 1, 8, 4'b1000, 8'b01000001, 3'b110, 2'b10, 3);
    // beq not taken
    add(0, BEQ, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 4);
    add(0, BEQ, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 4);
    add(0, BEQ, 0, 0, 8, 4'b0000, 8'b01000001, 3'b110, 2'b10, 4);
    // addi
    add(0, ADDI, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 5);
    add(0, ADDI, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 5);
    add(0, ADDI, 0, 0, 9, 4'b0000, 8'b01100000, 3'b010, 2'b00, 5);
    add(0, ADDI, 0, 0, 10, 4'b0001, 8'b00000000, 3'b010, 2'b10, 5);
    // j
    add(0, J, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 6);
    add(0, J, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 6);
    add(0, J, 0, 0, 11, 4'b1000, 8'b00000010, 3'b010, 2'b10, 6);
    // R-type with unsupported funct still completes
    add(0, RT, 6'b000000, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 7);
    add(0, RT, 6'b000000, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 7);
    add(0, RT, 6'b000000, 0, 6, 4'b0000, 8'b01000000, 3'b010, 2'b01, 7);
    add(0, RT, 6'b000000, 0, 7, 4'b0001, 8'b00001000, 3'b010, 2'b10, 7);
    // illegal opcode
    add(0, BAD, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 8);
    add(0, BAD, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b11, 8);
    // op 000101
    add(0, BNE, 0, 1, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 9);
`ifdef MC_CONTROLLER_BNE_EN
    add(0, BNE, 0, 1, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 9);
    add(0, BNE, 0, 1, 8, 4'b0000, 8'b01000001, 3'b110, 2'b10, 9);
    add(0, BNE, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 10);
    add(0, BNE, 0, 0, 1, 4'b0000, 8'b00110000, 3'b010, 2'b00, 10);
    add(0, BNE, 0, 0, 8, 4'b1000, 8'b01000001, 3'b110, 2'b10, 10);
    add(0, RT, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 11);
`else
    add(0, BNE, 0, 1, 1, 4'b0000, 8'b00110000, 3'b010, 2'b11, 9);
    add(0, RT, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 10);
    add(0, RT, 0, 0, 1, 4'b0000, 8'b00010000 | 8'b00100000, 3'b010, 2'b00, 10);
    add(0, RT, 0, 0, 6, 4'b0000, 8'b01000000, 3'b010, 2'b01, 10);
    add(0, RT, 0, 0, 7, 4'b0001, 8'b00001000, 3'b010, 2'b10, 10);
    add(0, RT, 0, 0, 0, 4'b1100, 8'b00010000, 3'b010, 2'b00, 11);
`endif

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].r; op = tbl[i].o;
      funct = tbl[i].f; zero = tbl[i].z;
      #1;
      chk($sformatf("row%0d_out", i), 32'(actual()), 32'(tbl[i].exp));
      chk($sformatf("row%0d_cnt", i), instr_count, 32'(tbl[i].cnt));
    end

    // beq: pcen follows zero combinationally inside BRANCH
    // (table ends in FETCH with count 11)
    op = BEQ; funct = '0; zero = 1'b0;
    @(negedge clk); #1;
    chk("beq_decode_state", 32'(state), 32'd1);
    @(negedge clk); #1;
    chk("beq_branch_state", 32'(state), 32'd8);
    chk("beq_pcen_z0", 32'(pcen), 32'd0);
    zero = 1'b1; #1;
    chk("beq_pcen_z1", 32'(pcen), 32'd1);
    zero = 1'b0; #1;
    chk("beq_pcen_z0b", 32'(pcen), 32'd0);
    @(negedge clk); #1;
    chk("beq_back_fetch", 32'(state), 32'd0);
    chk("beq_count", instr_count, 32'd12);

    // sw aborted by reset in MEMWR
    op = SW;
    repeat (3) @(negedge clk);
    #1;
    chk("sw_memwr_state", 32'(state), 32'd5);
    chk("sw_memwrite", 32'(memwrite), 32'd1);
    chk("sw_iord", 32'(iord), 32'd1);
    reset = 1'b1; #1;
    chk("rst_memwrite", 32'(memwrite), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sel_alusrcb", 32'(alusrcb), 32'd1);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_irwrite", 32'(irwrite), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
